// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_queue
//  Description : In-order write-back queue. Collects two-lane results from
//                several execution classes with round-robin arbitration,
//                drains up to two writes per cycle onto the register-file
//                write ports, and publishes a busy bitmap of pending writes.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_commit_queue #(
   parameter int EXEC_CLASS_NUM = 5,
   parameter int DEPTH          = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [EXEC_CLASS_NUM-1:0]     cls_valid_i,
   input  logic [2*EXEC_CLASS_NUM-1:0]   cls_lane_vld_i,
   input  logic [10*EXEC_CLASS_NUM-1:0]  cls_addr_i,
   input  logic [64*EXEC_CLASS_NUM-1:0]  cls_data_i,
   output logic [EXEC_CLASS_NUM-1:0]     cls_ready_o,
   output logic [1:0]                    rf_we_o,
   output logic [9:0]                    rf_waddr_o,
   output logic [63:0]                   rf_wdata_o,
   output logic [31:0]                   pend_busy_o,
   output logic [$clog2(DEPTH+1)-1:0]    q_count_o
);

   localparam int c_N  = EXEC_CLASS_NUM;
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH+1);
   localparam int c_RW = (c_N > 1) ? $clog2(c_N) : 1;

   logic [4:0]      addr_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [c_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0] count_q, count_d;
   logic [c_RW-1:0] rr_ptr_q, rr_ptr_d;
   logic [1:0]      rf_we_q, rf_we_d;
   logic [9:0]      rf_waddr_q, rf_waddr_d;
   logic [63:0]     rf_wdata_q, rf_wdata_d;

   logic [1:0]      lane_n [c_N];
   logic [c_RW-1:0] g0_idx, g1_idx;
   logic            have_g0, have_g1, acc0, acc1;
   logic [c_CW-1:0] free_cnt;
   logic [2:0]      enq_cnt;
   logic [4:0]      enq_addr [4];
   logic [31:0]     enq_data [4];
   logic [1:0]      deq_cnt;

   function automatic logic [c_RW-1:0] next_cls(input logic [c_RW-1:0] x);
      return (int'(x) == c_N - 1) ? '0 : x + c_RW'(1);
   endfunction

   // Per-class count of lanes that will actually occupy a queue entry
   always_comb begin
      for (int i = 0; i < c_N; i++) begin
         lane_n[i] = {1'b0, cls_lane_vld_i[2*i]   && (cls_addr_i[(2*i)*5   +: 5] != 5'd0)}
                   + {1'b0, cls_lane_vld_i[2*i+1] && (cls_addr_i[(2*i+1)*5 +: 5] != 5'd0)};
      end
   end

   // Pick the first two valid classes in round-robin order starting at rr_ptr
   always_comb begin
      int idx;
      idx     = 0;
      have_g0 = 1'b0;
      have_g1 = 1'b0;
      g0_idx  = '0;
      g1_idx  = '0;
      for (int k = 0; k < c_N; k++) begin
         idx = (int'(rr_ptr_q) + k) % c_N;
         if (cls_valid_i[idx]) begin
            if (!have_g0) begin
               have_g0 = 1'b1;
               g0_idx  = c_RW'(idx);
            end else if (!have_g1) begin
               have_g1 = 1'b1;
               g1_idx  = c_RW'(idx);
            end
         end
      end
   end

   // Space check against registered occupancy; refusing g0 blocks g1 so no class is bypassed
   always_comb begin
      free_cnt    = c_CW'(DEPTH) - count_q;
      acc0        = have_g0 && (int'(lane_n[g0_idx]) <= int'(free_cnt));
      acc1        = acc0 && have_g1 &&
                    (int'(lane_n[g0_idx]) + int'(lane_n[g1_idx]) <= int'(free_cnt));
      cls_ready_o = '0;
      if (acc0) cls_ready_o[g0_idx] = 1'b1;
      if (acc1) cls_ready_o[g1_idx] = 1'b1;
      rr_ptr_d = rr_ptr_q;
      if (acc1)      rr_ptr_d = next_cls(g1_idx);
      else if (acc0) rr_ptr_d = next_cls(g0_idx);
   end

   // Compact accepted lanes into up to four consecutive queue slots, g0 first
   always_comb begin
      logic [c_RW-1:0] sel;
      logic            en;
      int              ln;
      sel     = '0;
      en      = 1'b0;
      ln      = 0;
      enq_cnt = '0;
      for (int j = 0; j < 4; j++) begin
         enq_addr[j] = '0;
         enq_data[j] = '0;
      end
      for (int c = 0; c < 2; c++) begin
         sel = (c == 0) ? g0_idx : g1_idx;
         en  = (c == 0) ? acc0 : acc1;
         for (int l = 0; l < 2; l++) begin
            ln = 2*int'(sel) + l;
            if (en && cls_lane_vld_i[ln] && (cls_addr_i[ln*5 +: 5] != 5'd0)) begin
               enq_addr[enq_cnt[1:0]] = cls_addr_i[ln*5 +: 5];
               enq_data[enq_cnt[1:0]] = cls_data_i[ln*32 +: 32];
               enq_cnt                = enq_cnt + 3'd1;
            end
         end
      end
   end

   // Pop the two oldest entries; unused write port keeps its last address/data
   always_comb begin
      deq_cnt    = (count_q >= c_CW'(2)) ? 2'd2 : 2'(count_q);
      rf_we_d    = {deq_cnt == 2'd2, deq_cnt != 2'd0};
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (deq_cnt != 2'd0) begin
         rf_waddr_d[4:0]  = addr_q[rd_ptr_q];
         rf_wdata_d[31:0] = data_q[rd_ptr_q];
      end
      if (deq_cnt == 2'd2) begin
         rf_waddr_d[9:5]   = addr_q[rd_ptr_q + c_AW'(1)];
         rf_wdata_d[63:32] = data_q[rd_ptr_q + c_AW'(1)];
      end
      wr_ptr_d = wr_ptr_q + c_AW'(enq_cnt);
      rd_ptr_d = rd_ptr_q + c_AW'(deq_cnt);
      count_d  = count_q + c_CW'(enq_cnt) - c_CW'(deq_cnt);
   end

   // Busy bitmap: any live entry (between rd_ptr and rd_ptr+count) marks its register
   always_comb begin
      logic [c_AW-1:0] off;
      off         = '0;
      pend_busy_o = '0;
      for (int e = 0; e < DEPTH; e++) begin
         off = c_AW'(e) - rd_ptr_q;
         if (c_CW'(off) < count_q) pend_busy_o[addr_q[e]] = 1'b1;
      end
   end

   // Queue storage; slots beyond the live window are don't-care so no reset needed
   always_ff @(posedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (j < int'(enq_cnt)) begin
            addr_q[wr_ptr_q + c_AW'(j)] <= enq_addr[j];
            data_q[wr_ptr_q + c_AW'(j)] <= enq_data[j];
         end
      end
   end

   // Control state and registered write-port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_ptr_q   <= '0;
         rf_we_q    <= '0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rr_ptr_q   <= rr_ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign q_count_o  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit_queue
//  Description : Self-checking bench for wb_commit_queue with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_commit_queue;

   localparam int N = 5;
   localparam int D = 8;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    cls_valid = '0;
   logic [2*N-1:0]  lane = '0;
   logic [10*N-1:0] addr = '0;
   logic [64*N-1:0] data = '0;

   logic [N-1:0] ready, ready4;
   logic [1:0]   we, we4;
   logic [9:0]   waddr, waddr4;
   logic [63:0]  wdata, wdata4;
   logic [31:0]  pend, pend4;
   logic [3:0]   qc;
   logic [2:0]   qc4;

   int total = 0;
   int bad   = 0;

   ent_t        mq[$];
   int          m_rr;
   logic [1:0]  m_we;
   logic [9:0]  m_waddr;
   logic [63:0] m_wdata;

   wb_commit_queue #(.EXEC_CLASS_NUM(N), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .cls_valid_i(cls_valid), .cls_lane_vld_i(lane),
      .cls_addr_i(addr), .cls_data_i(data), .cls_ready_o(ready), .rf_we_o(we),
      .rf_waddr_o(waddr), .rf_wdata_o(wdata), .pend_busy_o(pend), .q_count_o(qc));

   wb_commit_queue #(.EXEC_CLASS_NUM(N), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .cls_valid_i(cls_valid), .cls_lane_vld_i(lane),
      .cls_addr_i(addr), .cls_data_i(data), .cls_ready_o(ready4), .rf_we_o(we4),
      .rf_waddr_o(waddr4), .rf_wdata_o(wdata4), .pend_busy_o(pend4), .q_count_o(qc4));

   always #5 clk = ~clk;

   function automatic int nl(int c);
      int n = 0;
      for (int l = 0; l < 2; l++)
         if (lane[2*c+l] && addr[(2*c+l)*5 +: 5] != 5'd0) n++;
      return n;
   endfunction

   // Expected ready set from the arbitration rules applied to the model queue
   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r = '0;
      int free = D - mq.size();
      int got = 0;
      int need = 0;
      bit stop = 0;
      for (int k = 0; k < N; k++) begin
         int idx = (m_rr + k) % N;
         if (!stop && cls_valid[idx]) begin
            if (got == 0) begin
               if (nl(idx) <= free) begin r[idx] = 1'b1; need = nl(idx); got = 1; end
               else stop = 1;
            end else begin
               if (need + nl(idx) <= free) r[idx] = 1'b1;
               stop = 1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_pend();
      logic [31:0] b = '0;
      foreach (mq[i]) b[mq[i].a] = 1'b1;
      return b;
   endfunction

   task automatic model_edge(input logic [N-1:0] acc);
      int npop;
      int last;
      int base;
      ent_t e;
      npop = (mq.size() < 2) ? mq.size() : 2;
      if (npop >= 1) begin e = mq.pop_front(); m_waddr[4:0] = e.a; m_wdata[31:0] = e.d; end
      if (npop == 2) begin e = mq.pop_front(); m_waddr[9:5] = e.a; m_wdata[63:32] = e.d; end
      m_we = (npop == 2) ? 2'b11 : (npop == 1) ? 2'b01 : 2'b00;
      base = m_rr;
      last = -1;
      for (int k = 0; k < N; k++) begin
         int idx = (base + k) % N;
         if (acc[idx]) begin
            for (int l = 0; l < 2; l++)
               if (lane[2*idx+l] && addr[(2*idx+l)*5 +: 5] != 5'd0)
                  mq.push_back('{a: addr[(2*idx+l)*5 +: 5], d: data[(2*idx+l)*32 +: 32]});
            last = idx;
         end
      end
      if (last >= 0) m_rr = (last + 1) % N;
   endtask

   task automatic model_reset();
      mq.delete();
      m_rr = 0; m_we = '0; m_waddr = '0; m_wdata = '0;
   endtask

   // One clock edge: model advances, producers drop requests that were accepted
   task automatic cycle(output logic [N-1:0] acc);
      acc = exp_ready();
      model_edge(acc);
      @(posedge clk);
      #1;
      cls_valid = cls_valid & ~acc;
   endtask

   task automatic clear_inputs();
      cls_valid = '0; lane = '0; addr = '0; data = '0;
   endtask

   task automatic set_lane(input int c, input int l, input logic [4:0] a, input logic [31:0] d);
      lane[2*c+l] = 1'b1;
      addr[(2*c+l)*5 +: 5] = a;
      data[(2*c+l)*32 +: 32] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      total++; if (qc !== 4'd0) begin bad++; $display("FAIL reset_qcount got=%0d want=0", qc); end
      total++; if (we !== 2'b00) begin bad++; $display("FAIL reset_we got=%b want=00", we); end
      total++; if (waddr !== 10'd0) begin bad++; $display("FAIL reset_waddr got=%h want=0", waddr); end
      total++; if (wdata !== 64'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
      total++; if (pend !== 32'd0) begin bad++; $display("FAIL reset_pend got=%h want=0", pend); end
      total++; if (ready !== 5'd0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
      total++; if (qc4 !== 3'd0) begin bad++; $display("FAIL reset_qcount4 got=%0d want=0", qc4); end
   endtask

   task automatic test_single();
      logic [N-1:0] acc;
      clear_inputs();
      cls_valid[2] = 1'b1;
      set_lane(2, 0, 5'd5, 32'hDEADBEEF);
      #1;
      total++; if (ready !== 5'b00100) begin bad++; $display("FAIL single_ready got=%b want=00100", ready); end
      cycle(acc);
      total++; if (qc !== 4'd1) begin bad++; $display("FAIL single_qcount got=%0d want=1", qc); end
      total++; if (pend !== 32'h20) begin bad++; $display("FAIL single_pend_set got=%h want=20", pend); end
      cycle(acc);
      total++; if (pend !== 32'h0) begin bad++; $display("FAIL single_pend_clr got=%h want=0", pend); end
      total++; if (we !== 2'b01) begin bad++; $display("FAIL single_we got=%b want=01", we); end
      total++; if (waddr[4:0] !== 5'd5) begin bad++; $display("FAIL single_waddr got=%0d want=5", waddr[4:0]); end
      total++; if (wdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h want=deadbeef", wdata[31:0]); end
      cycle(acc);
      total++; if (we !== 2'b00) begin bad++; $display("FAIL single_we_idle got=%b want=00", we); end
   endtask

   task automatic test_compact();
      logic [N-1:0] acc;
      clear_inputs();
      cls_valid = 5'b00011;
      set_lane(0, 1, 5'd7, 32'd1);
      set_lane(1, 0, 5'd0, 32'h55);
      #1;
      total++; if (ready !== 5'b00011) begin bad++; $display("FAIL compact_ready got=%b want=00011", ready); end
      cycle(acc);
      total++; if (qc !== 4'd1) begin bad++; $display("FAIL compact_qcount got=%0d want=1", qc); end
      total++; if (pend !== 32'h80) begin bad++; $display("FAIL compact_pend got=%h want=80", pend); end
      cycle(acc);
      total++; if (we !== 2'b01) begin bad++; $display("FAIL compact_we got=%b want=01", we); end
      total++; if (waddr[4:0] !== 5'd7) begin bad++; $display("FAIL compact_waddr got=%0d want=7", waddr[4:0]); end
      total++; if (wdata[31:0] !== 32'd1) begin bad++; $display("FAIL compact_wdata got=%h want=1", wdata[31:0]); end
      cycle(acc);
      total++; if (we !== 2'b00) begin bad++; $display("FAIL compact_zero_addr_written got=%b want=00", we); end
   endtask

   task automatic test_all_one_lane();
      logic [N-1:0] acc;
      logic [N-1:0] exp_r [3];
      ent_t got[$];
      exp_r[0] = 5'b00011; exp_r[1] = 5'b01100; exp_r[2] = 5'b10000;
      do_reset();
      for (int i = 0; i < N; i++) begin
         cls_valid[i] = 1'b1;
         set_lane(i, 0, 5'(10 + i), 32'hA0000000 + 32'(i));
      end
      for (int c = 0; c < 7; c++) begin
         if (c < 3) begin
            #1;
            total++; if (ready !== exp_r[c]) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", c, ready, exp_r[c]); end
         end
         cycle(acc);
         if (we[0]) got.push_back('{a: waddr[4:0], d: wdata[31:0]});
         if (we[1]) got.push_back('{a: waddr[9:5], d: wdata[63:32]});
      end
      total++; if (got.size() != 5) begin bad++; $display("FAIL rr_write_count got=%0d want=5", got.size()); end
      foreach (got[i]) begin
         total++;
         if (got[i].a !== 5'(10 + i) || got[i].d !== 32'hA0000000 + 32'(i)) begin
            bad++; $display("FAIL rr_write%0d got=%0d/%h want=%0d/%h", i, got[i].a, got[i].d, 10 + i, 32'hA0000000 + 32'(i));
         end
      end
      clear_inputs();
      cls_valid = 5'b11010;
      #1;
      total++; if (ready !== 5'b01010) begin bad++; $display("FAIL rr_wrap got=%b want=01010", ready); end
      cycle(acc);
      clear_inputs();
   endtask

   task automatic test_mid_reset();
      logic [N-1:0] acc;
      do_reset();
      cls_valid = 5'b00011;
      set_lane(0, 0, 5'd1, 32'h1); set_lane(0, 1, 5'd2, 32'h2);
      set_lane(1, 0, 5'd3, 32'h3); set_lane(1, 1, 5'd4, 32'h4);
      #1;
      total++; if (ready !== 5'b00011) begin bad++; $display("FAIL mreset_ready0 got=%b want=00011", ready); end
      cycle(acc);
      clear_inputs();
      cls_valid = 5'b01100;
      set_lane(2, 0, 5'd5, 32'h5); set_lane(2, 1, 5'd6, 32'h6);
      set_lane(3, 0, 5'd7, 32'h7); set_lane(3, 1, 5'd8, 32'h8);
      #1;
      total++; if (ready !== 5'b01100) begin bad++; $display("FAIL mreset_ready1 got=%b want=01100", ready); end
      cycle(acc);
      total++; if (qc !== 4'd6) begin bad++; $display("FAIL mreset_fill got=%0d want=6", qc); end
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      total++; if (qc !== 4'd0) begin bad++; $display("FAIL mreset_qcount got=%0d want=0", qc); end
      total++; if (we !== 2'b00) begin bad++; $display("FAIL mreset_we got=%b want=00", we); end
      total++; if (pend !== 32'd0) begin bad++; $display("FAIL mreset_pend got=%h want=0", pend); end
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         cycle(acc);
         total++; if (we !== 2'b00) begin bad++; $display("FAIL mreset_stale_write%0d got=%b want=00", c, we); end
      end
   endtask

   task automatic test_refuse();
      do_reset();
      cls_valid = 5'b00011;
      set_lane(0, 0, 5'd1, 32'd11); set_lane(0, 1, 5'd2, 32'd22); set_lane(1, 0, 5'd3, 32'd33);
      #1;
      total++; if (ready4 !== 5'b00011) begin bad++; $display("FAIL refuse_fill got=%b want=00011", ready4); end
      @(posedge clk); #1;
      clear_inputs();
      cls_valid = 5'b00101;
      set_lane(2, 0, 5'd4, 32'd44); set_lane(2, 1, 5'd5, 32'd55); set_lane(0, 0, 5'd6, 32'd66);
      #1;
      total++; if (ready4 !== 5'b00000) begin bad++; $display("FAIL refuse_g0 got=%b want=00000", ready4); end
      total++; if (qc4 !== 3'd3) begin bad++; $display("FAIL refuse_qcount got=%0d want=3", qc4); end
      total++; if (pend4 !== 32'h0E) begin bad++; $display("FAIL refuse_pend got=%h want=0e", pend4); end
      @(posedge clk); #1;
      total++; if (qc4 !== 3'd1) begin bad++; $display("FAIL refuse_drain got=%0d want=1", qc4); end
      total++; if (ready4 !== 5'b00101) begin bad++; $display("FAIL refuse_retry got=%b want=00101", ready4); end
      total++; if (we4 !== 2'b11 || waddr4 !== {5'd2, 5'd1} || wdata4 !== {32'd22, 32'd11}) begin
         bad++; $display("FAIL refuse_pair_write got=%b/%h/%h want=11/%h/%h", we4, waddr4, wdata4, {5'd2, 5'd1}, {32'd22, 32'd11});
      end
      @(posedge clk); #1;
      clear_inputs();
      #1;
      total++; if (qc4 !== 3'd3) begin bad++; $display("FAIL refuse_after got=%0d want=3", qc4); end
      total++; if (pend4 !== 32'h70) begin bad++; $display("FAIL refuse_pend_after got=%h want=70", pend4); end
      total++; if (we4 !== 2'b01 || waddr4 !== {5'd2, 5'd3} || wdata4[31:0] !== 32'd33) begin
         bad++; $display("FAIL refuse_single_write got=%b/%h/%h want=01/%h/21", we4, waddr4, wdata4[31:0], {5'd2, 5'd3});
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [N-1:0] acc;
      logic [N-1:0] er;
      int wait_c[N];
      int acc_n[N];
      int maxw;
      bit heavy;
      maxw = 0;
      for (int i = 0; i < N; i++) begin wait_c[i] = 0; acc_n[i] = 0; end
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         heavy = (cyc < 150);
         for (int i = 0; i < N; i++) begin
            if (!cls_valid[i]) begin
               lane[2*i +: 2] = '0;
               wait_c[i] = 0;
               if (heavy || $urandom_range(0, 9) < 6) begin
                  cls_valid[i] = 1'b1;
                  lane[2*i +: 2] = heavy ? 2'b11 : 2'($urandom_range(0, 3));
                  for (int l = 0; l < 2; l++) begin
                     addr[(2*i+l)*5 +: 5] = (!heavy && $urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                     data[(2*i+l)*32 +: 32] = $urandom;
                  end
               end
            end
         end
         #1;
         er = exp_ready();
         total++; if (ready !== er) begin bad++; $display("FAIL rnd_ready c%0d got=%b want=%b", cyc, ready, er); end
         total++; if (qc !== 4'(mq.size())) begin bad++; $display("FAIL rnd_qcount c%0d got=%0d want=%0d", cyc, qc, mq.size()); end
         total++; if (qc > 4'(D)) begin bad++; $display("FAIL rnd_overflow c%0d got=%0d want<=%0d", cyc, qc, D); end
         total++; if (pend !== exp_pend()) begin bad++; $display("FAIL rnd_pend c%0d got=%h want=%h", cyc, pend, exp_pend()); end
         total++; if (we !== m_we) begin bad++; $display("FAIL rnd_we c%0d got=%b want=%b", cyc, we, m_we); end
         total++; if (waddr !== m_waddr) begin bad++; $display("FAIL rnd_waddr c%0d got=%h want=%h", cyc, waddr, m_waddr); end
         total++; if (wdata !== m_wdata) begin bad++; $display("FAIL rnd_wdata c%0d got=%h want=%h", cyc, wdata, m_wdata); end
         cycle(acc);
         for (int i = 0; i < N; i++) begin
            if (acc[i]) acc_n[i]++;
            else if (cls_valid[i]) begin
               wait_c[i]++;
               if (wait_c[i] > maxw) maxw = wait_c[i];
            end
         end
      end
      total++; if (maxw > 20) begin bad++; $display("FAIL rnd_starve got=%0d want<=20", maxw); end
      for (int i = 0; i < N; i++) begin
         total++; if (acc_n[i] == 0) begin bad++; $display("FAIL rnd_class%0d_served got=0 want>0", i); end
      end
      clear_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_compact();
      test_all_one_lane();
      test_mid_reset();
      test_refuse();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
